// File: rtl/apb_regbus_pkg.sv
// Shared types and defaults for the APB-to-register-bus bridge.
package apb_regbus_pkg;

  localparam int unsigned APB_AW_DFLT = 16;
  localparam int unsigned ADDR_W_DFLT = 8;
  localparam int unsigned DATA_W_DFLT = 32;

  localparam int unsigned ERR_W = 2;
  localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
  localparam logic [ERR_W-1:0] ERR_DECODE  = 2'd1;
  localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    ERR  = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/apb_regbus_bridge.sv
// APB3 slave turning each transfer into one register-bus access, with decode
// error and read-timeout reporting through pslverr.
module apb_regbus_bridge
  import apb_regbus_pkg::*;
#(
  parameter int unsigned APB_AW  = APB_AW_DFLT,
  parameter int unsigned ADDR_W  = ADDR_W_DFLT,
  parameter int unsigned DATA_W  = DATA_W_DFLT,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [APB_AW-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] addr,
  output logic              chip_select,
  output logic              write_en,
  output logic              read_en,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              data_valid,
  output logic              timeout_evt
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic [ERR_W-1:0]  cause_q, cause_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic              decode_err_c;

  // Byte address must be word aligned and fit inside the register file.
  assign decode_err_c = (paddr[1:0] != 2'b00) || ((paddr >> (ADDR_W + 2)) != '0);

  assign timeout_evt = tmo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      prdata_q <= '0;
      cause_q  <= ERR_NONE;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      prdata_q <= prdata_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    prdata_d    = prdata_q;
    cause_d     = cause_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    chip_select = 1'b0;
    write_en    = 1'b0;
    read_en     = 1'b0;
    addr        = '0;
    write_data  = '0;
    pready      = 1'b0;
    pslverr     = 1'b0;
    prdata      = '0;

    unique case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          addr_d   = paddr[ADDR_W+1:2];
          pwrite_d = pwrite;
          pwdata_d = pwdata;
          prdata_d = '0;
          cause_d  = ERR_NONE;
          cnt_d    = '0;
          if (decode_err_c) state_d = ERR;
          else if (pwrite)  state_d = WR;
          else              state_d = RD;
        end
      end
      WR: begin
        chip_select = 1'b1;
        write_en    = 1'b1;
        addr        = addr_q;
        write_data  = pwdata_q;
        state_d     = RESP;
      end
      RD: begin
        chip_select = 1'b1;
        read_en     = 1'b1;
        addr        = addr_q;
        cnt_d       = CNT_W'(cnt_q + 1'b1);
        // A completion arriving on the last allowed cycle still wins.
        if (data_valid) begin
          prdata_d = read_data;
          cause_d  = ERR_NONE;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prdata_d = '0;
          cause_d  = ERR_TIMEOUT;
          tmo_d    = 1'b1;
          state_d  = RESP;
        end
      end
      ERR: begin
        prdata_d = '0;
        cause_d  = ERR_DECODE;
        state_d  = RESP;
      end
      RESP: begin
        // A master that dropped psel gets no response; nothing is buffered.
        pready  = psel && penable;
        pslverr = pready && (cause_q != ERR_NONE);
        prdata  = (pready && !pwrite_q) ? prdata_q : '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_regbus_bridge.sv
// Self-checking bench: directed table, reset-in-read sequence and random
// transfers scored against a word-level model of the bridge's behaviour.
module tb_apb_regbus_bridge;
  import apb_regbus_pkg::*;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic [7:0]  addr;
  logic        chip_select, write_en, read_en;
  logic [31:0] write_data, read_data;
  logic        data_valid, timeout_evt;

  int n_chk  = 0;
  int n_fail = 0;

  apb_regbus_bridge #(.APB_AW(16), .ADDR_W(8), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .addr(addr), .chip_select(chip_select),
    .write_en(write_en), .read_en(read_en), .write_data(write_data),
    .read_data(read_data), .data_valid(data_valid), .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  // Register-file model: completes a read rf_lat cycles after the strobe starts.
  logic [31:0] rf_mem [256] = '{default: '0};
  int          rf_lat = 1;
  int          rd_cyc;
  assign read_data = rf_mem[addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_valid <= 1'b0;
      rd_cyc     <= 0;
    end else begin
      if (write_en) rf_mem[addr] <= write_data;
      data_valid <= read_en && (rd_cyc + 1 >= rf_lat);
      rd_cyc     <= read_en ? rd_cyc + 1 : 0;
    end
  end

  // Bus monitor: cumulative activity counts and protocol-rule violations.
  int          cs_cnt = 0, we_cnt = 0, re_cnt = 0, tmo_cnt = 0;
  int          ovl_cnt = 0, stray_cnt = 0, leak_cnt = 0;
  logic [7:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    cs_cnt  <= cs_cnt + int'(chip_select);
    we_cnt  <= we_cnt + int'(write_en);
    re_cnt  <= re_cnt + int'(read_en);
    tmo_cnt <= tmo_cnt + int'(timeout_evt);
    if (write_en && read_en) ovl_cnt <= ovl_cnt + 1;
    if (chip_select != (write_en || read_en)) stray_cnt <= stray_cnt + 1;
    if (!pready && (pslverr || prdata != '0)) leak_cnt <= leak_cnt + 1;
    if (write_en) begin
      last_waddr <= addr;
      last_wdata <= write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model at word level: decode, memory image, latency rule.
  logic [31:0] ref_mem [256] = '{default: '0};

  task automatic model(input bit wr, input logic [15:0] pa, input logic [31:0] wd,
                       input int lat, output logic [31:0] erd, output bit eerr,
                       output int ewaits, output int ewe, output int ere, output int etmo);
    int word;
    bit bad;
    bad  = (int'(pa) % 4 != 0) || (int'(pa) >= 4 * 256);
    word = int'(pa) / 4;
    erd = '0; eerr = 1'b0; ewe = 0; ere = 0; etmo = 0; ewaits = 1;
    if (bad) begin
      eerr = 1'b1;
    end else if (wr) begin
      ref_mem[word] = wd;
      ewe = 1;
    end else if (lat <= int'(TIMEOUT) - 1) begin
      erd    = ref_mem[word];
      ewaits = lat + 1;
      ere    = lat + 1;
    end else begin
      eerr   = 1'b1;
      ewaits = TIMEOUT;
      ere    = TIMEOUT;
      etmo   = 1;
    end
  endtask

  // One APB transfer; starts right after a rising edge, ends the same way.
  task automatic xfer(input bit wr, input logic [15:0] pa, input logic [31:0] wd, input int lat,
                      output logic [31:0] rd, output bit err, output int waits);
    bit done = 1'b0;
    rf_lat  = lat;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = pa;
    pwdata  = wd;
    rd      = '0;
    err     = 1'b0;
    waits   = 0;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (pready) begin
        done = 1'b1;
        rd   = prdata;
        err  = pslverr;
      end else begin
        waits++;
      end
    end
    n_chk++;
    if (!done) begin
      n_fail++;
      $display("FAIL pready_wait: got no pready in 40 cycles, expected pready");
    end
    @(posedge clk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  // Runs a transfer and compares every observable against the given expectations.
  task automatic run_cmp(input string tag, input bit wr, input logic [15:0] pa,
                         input logic [31:0] wd, input int lat, input logic [31:0] erd,
                         input bit eerr, input int ewaits, input int ewe, input int ere,
                         input int etmo);
    logic [31:0] rd;
    bit          err;
    int          waits;
    int cs0 = cs_cnt, we0 = we_cnt, re0 = re_cnt, tm0 = tmo_cnt;
    xfer(wr, pa, wd, lat, rd, err, waits);
    check({tag, ".rdata"}, rd, erd);
    check({tag, ".pslverr"}, 32'(err), 32'(eerr));
    check({tag, ".waits"}, 32'(waits), 32'(ewaits));
    check({tag, ".write_en"}, 32'(we_cnt - we0), 32'(ewe));
    check({tag, ".read_en"}, 32'(re_cnt - re0), 32'(ere));
    check({tag, ".chip_select"}, 32'(cs_cnt - cs0), 32'(ewe + ere));
    check({tag, ".timeout_evt"}, 32'(tmo_cnt - tm0), 32'(etmo));
    if (ewe != 0) begin
      check({tag, ".addr"}, 32'(last_waddr), 32'(pa[9:2]));
      check({tag, ".write_data"}, last_wdata, wd);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] pa;
    logic [31:0] wd;
    int          lat;
    logic [31:0] rd;
    bit          err;
    int          waits;
    int          we;
    int          re;
    int          tmo;
  } vec_t;

  vec_t vecs[10];

  initial begin
    logic [31:0] erd;
    bit          eerr;
    int          ew, ewe, ere, etm;

    vecs[0] = '{1'b1, 16'h0008, 32'hA5A5_0001, 1,  32'h0,         1'b0, 1, 1, 0, 0};
    vecs[1] = '{1'b1, 16'h000C, 32'h1234_5678, 1,  32'h0,         1'b0, 1, 1, 0, 0};
    vecs[2] = '{1'b0, 16'h000C, 32'h0,         1,  32'h1234_5678, 1'b0, 2, 0, 2, 0};
    vecs[3] = '{1'b0, 16'h000C, 32'h0,         99, 32'h0,         1'b1, 8, 0, 8, 1};
    vecs[4] = '{1'b1, 16'h0006, 32'hFFFF_FFFF, 1,  32'h0,         1'b1, 1, 0, 0, 0};
    vecs[5] = '{1'b0, 16'h0400, 32'h0,         1,  32'h0,         1'b1, 1, 0, 0, 0};
    vecs[6] = '{1'b1, 16'h0004, 32'hCAFE_F00D, 1,  32'h0,         1'b0, 1, 1, 0, 0};
    vecs[7] = '{1'b0, 16'h0004, 32'h0,         1,  32'hCAFE_F00D, 1'b0, 2, 0, 2, 0};
    vecs[8] = '{1'b0, 16'h0008, 32'h0,         7,  32'hA5A5_0001, 1'b0, 8, 0, 8, 0};
    vecs[9] = '{1'b0, 16'h0008, 32'h0,         8,  32'h0,         1'b1, 8, 0, 8, 1};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    check("reset.prdata", prdata, 32'h0);
    check("reset.flags", 32'({pready, pslverr, chip_select, write_en, read_en, timeout_evt}), 32'h0);
    check("reset.addr", 32'(addr), 32'h0);
    check("reset.write_data", write_data, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table; the model is still run so its memory image tracks the DUT.
    for (int i = 0; i < 10; i++) begin
      model(vecs[i].wr, vecs[i].pa, vecs[i].wd, vecs[i].lat, erd, eerr, ew, ewe, ere, etm);
      run_cmp($sformatf("vec%0d", i), vecs[i].wr, vecs[i].pa, vecs[i].wd, vecs[i].lat,
              vecs[i].rd, vecs[i].err, vecs[i].waits, vecs[i].we, vecs[i].re, vecs[i].tmo);
    end

    // Reset asserted during the second read-strobe cycle.
    rf_lat  = 99;
    psel    = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 16'h0000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check("rst_rd.read_en_before", 32'(read_en), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_rd.read_en", 32'(read_en), 32'h0);
    check("rst_rd.chip_select", 32'(chip_select), 32'h0);
    check("rst_rd.pready", 32'(pready), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model(1'b1, 16'h0000, 32'h0BAD_F00D, 1, erd, eerr, ew, ewe, ere, etm);
    run_cmp("post_rst_wr", 1'b1, 16'h0000, 32'h0BAD_F00D, 1, 32'h0, 1'b0, 1, 1, 0, 0);
    model(1'b0, 16'h0000, 32'h0, 1, erd, eerr, ew, ewe, ere, etm);
    run_cmp("post_rst_rd", 1'b0, 16'h0000, 32'h0, 1, 32'h0BAD_F00D, 1'b0, 2, 0, 2, 0);

    // Randomized transfers against the model.
    for (int i = 0; i < 60; i++) begin
      bit          wr;
      logic [15:0] pa;
      logic [31:0] wd;
      int          lat, sel;
      wr  = 1'($urandom_range(0, 1));
      pa  = 16'($urandom_range(0, 15) * 4);
      sel = int'($urandom_range(0, 7));
      if (sel == 0) pa = pa | 16'($urandom_range(1, 3));
      if (sel == 1) pa = pa | (16'h0400 << $urandom_range(0, 5));
      wd  = $urandom;
      lat = int'($urandom_range(1, 10));
      model(wr, pa, wd, lat, erd, eerr, ew, ewe, ere, etm);
      run_cmp($sformatf("rnd%0d", i), wr, pa, wd, lat, erd, eerr, ew, ewe, ere, etm);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    check("strobe_overlap", 32'(ovl_cnt), 32'h0);
    check("strobe_without_cs", 32'(stray_cnt), 32'h0);
    check("resp_outside_pready", 32'(leak_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
